scmp_microcode_seq: RTL and testbench
=====================================

# scmp_microcode_seq

Microcode sequencer for the SC/MP core: owns the microcode program counter (`upc`) that addresses the microcode ROM and picks the next address each cycle. It sits directly downstream of the opcode-to-entry-point decoder: at a DECODE step it consumes the decoded entry address `op_pc`. The same logic also handles:
- memory-cycle stalls;
- conditional microbranches;
- the HALT wait;
- the long DLY instruction countdown.

## Interface
- `UPC_W`, 7: microcode address width; `NEXTPC_t` is `UPC_W` bits.
- `DLY_W`, 18: delay counter width, large enough for the maximum SC/MP DLY count.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `op_pc`  in  UPC_W  decoded microcode entry address for the current opcode.
- `uc_nxt`  in  3  next-address mode of the current microword (`NXT_t`).
- `uc_jmp`  in  UPC_W  branch target field of the current microword.
- `uc_cond`  in  2  condition select (`COND_t`): ALWAYS, Z, NZ, POS.
- `uc_mem`  in  1  current microword performs a bus cycle.
- `uc_dly_ld`  in  1  current microword loads the delay counter.
- `dly_val`  in  DLY_W  delay count computed by the datapath.
- `mem_ack`  in  1  bus cycle complete.
- `flag_z`  in  1  accumulator == 0.
- `flag_ac7`  in  1  accumulator bit 7.
- `cont`  in  1  continue request; releases HALT.
- `upc`  out  UPC_W  registered microcode address.
- `halted`  out  1  sequencer is parked in HALT.
- `dly_busy`  out  1  delay counter nonzero.
- `decode_stb`  out  1  one-cycle pulse in the cycle `op_pc` is taken.

## Operation
- The `uc_*` fields are combinational functions of `upc`. In each cycle the sequencer evaluates them and registers the next `upc`.
- Stall has top priority: if `uc_mem` is 1 and `mem_ack` is 0, `upc` holds and no other action takes effect. `uc_dly_ld` is also suppressed while stalled.
- Next-address modes, applied when not stalled:
  - NXT_NEXT: `upc`+1, modulo 2^UPC_W (wrap 127→0 at default width).
  - NXT_JMP: `uc_jmp`.
  - NXT_COND: `uc_jmp` if the condition is true, else `upc`+1. Conditions: ALWAYS=1, Z=`flag_z`, NZ=!`flag_z`, POS=!`flag_ac7`.
  - NXT_DECODE: `op_pc`; `decode_stb`=1 in this cycle.
  - NXT_FETCH: `UCLBL_FETCH`.
  - NXT_HALT: `halted`=1 while this step is current. If `cont`=1 → `UCLBL_FETCH`, else hold. A `cont` present in the first HALT cycle exits immediately, so HALT lasts at least 1 cycle. `cont` outside HALT is ignored.
  - NXT_DLY: if the counter is nonzero, hold and decrement by 1. When the counter is 0, `upc`+1.
- Delay counter:
  - `uc_dly_ld` (not stalled) loads `dly_val`.
  - A load in the same cycle as NXT_DLY wins: no decrement that cycle, and the wait starts next cycle.
  - The counter never underflows; it saturates at 0.
  - Loading 0 makes NXT_DLY fall through in one cycle.
- Unused `NXT_t` codes behave as NXT_FETCH.

## Timing
- Reset (`rst_n` low, async):
  - `upc`=`UCLBL_FETCH`;
  - delay counter=0;
  - `halted`=0, `dly_busy`=0, `decode_stb`=0.
- Reset mid-stall, mid-delay or mid-halt abandons the operation. The first cycle after release executes FETCH.
- Outputs:
  - `upc` and the delay counter are registered.
  - `halted` and `decode_stb` are combinational from the current microword.
  - `dly_busy` is combinational from the counter register.
- Latency:
  - one cycle per microstep;
  - a bus step takes 1 + (cycles until `mem_ack`);
  - NXT_DLY with N loaded takes N+1 cycles.
- `mem_ack` is sampled only when `uc_mem`=1. An ack arriving with `uc_mem`=0 has no effect.

## Structure
- `scmp_microcode_pak` holds:
  - `NXT_t` enum: NEXT, JMP, COND, DECODE, FETCH, HALT, DLY;
  - `COND_t`;
  - `NEXTPC_t`;
  - the `UCLBL_*` constants, including `UCLBL_FETCH`.
- One sub-module, `scmp_dly_counter`: load / decrement / zero-flag, parameterised by `DLY_W`.
- The next-address mux stays in the top module.

## Test plan
- Reset asserted mid-NXT_DLY with counter=500 → `upc`=`UCLBL_FETCH`, `dly_busy`=0 at once, and FETCH runs after release.
- NXT_DECODE with `op_pc`=0x23 → next `upc`=0x23, and `decode_stb` is high for exactly that cycle.
- Stall: `uc_mem`=1 with `mem_ack` low for 3 cycles → `upc` is held 3 cycles and advances on the ack cycle. `uc_dly_ld` asserted during the stall has no effect.
- Branches:
  - NXT_COND/Z with `flag_z`=1, `uc_jmp`=0x40 → `upc`=0x40;
  - same with `flag_z`=0 at `upc`=0x7F → `upc`=0x00 (wrap).
- Delay: `dly_val`=5 load followed by NXT_DLY → 6 cycles at the DLY step, then `upc`+1. Load and NXT_DLY in the same cycle → wait starts next cycle.
- HALT:
  - no `cont` for 10 cycles → `halted`=1 and `upc` unchanged;
  - `cont` pulse → next `upc`=`UCLBL_FETCH` and `halted` drops;
  - `cont` present in the first HALT cycle → HALT lasts 1 cycle.

Source files
------------

// File: rtl/scmp_microcode_seq_pkg.sv
// Shared types and constants for the SC/MP microcode sequencer: next-address
// modes, branch conditions, microcode address type and entry-point labels.
package scmp_microcode_pak;

  localparam int UPC_W = 7;
  localparam int DLY_W = 18;

  typedef logic [UPC_W-1:0] NEXTPC_t;

  typedef enum logic [2:0] {
    NXT_NEXT   = 3'd0,
    NXT_JMP    = 3'd1,
    NXT_COND   = 3'd2,
    NXT_DECODE = 3'd3,
    NXT_FETCH  = 3'd4,
    NXT_HALT   = 3'd5,
    NXT_DLY    = 3'd6
  } NXT_t;

  typedef enum logic [1:0] {
    COND_ALWAYS = 2'd0,
    COND_Z      = 2'd1,
    COND_NZ     = 2'd2,
    COND_POS    = 2'd3
  } COND_t;

  localparam NEXTPC_t UCLBL_FETCH  = 7'h08;
  localparam NEXTPC_t UCLBL_DECODE = 7'h09;
  localparam NEXTPC_t UCLBL_DLY    = 7'h70;
  localparam NEXTPC_t UCLBL_HALT   = 7'h7C;

  function automatic logic cond_met(input COND_t sel, input logic flag_z, input logic flag_ac7);
    logic met;
    unique case (sel)
      COND_ALWAYS: met = 1'b1;
      COND_Z:      met = flag_z;
      COND_NZ:     met = !flag_z;
      COND_POS:    met = !flag_ac7;
      default:     met = 1'b0;
    endcase
    return met;
  endfunction

endpackage

// File: rtl/scmp_microcode_seq_if.sv
// Microword/status bundle between the microcode ROM + datapath and the sequencer.
interface scmp_microcode_seq_if;
  import scmp_microcode_pak::*;

  NEXTPC_t           op_pc;
  NXT_t              uc_nxt;
  NEXTPC_t           uc_jmp;
  COND_t             uc_cond;
  logic              uc_mem;
  logic              uc_dly_ld;
  logic [DLY_W-1:0]  dly_val;
  logic              mem_ack;
  logic              flag_z;
  logic              flag_ac7;
  logic              cont;
  NEXTPC_t           upc;
  logic              halted;
  logic              dly_busy;
  logic              decode_stb;

  modport master (
    input  op_pc, uc_nxt, uc_jmp, uc_cond, uc_mem, uc_dly_ld, dly_val,
           mem_ack, flag_z, flag_ac7, cont,
    output upc, halted, dly_busy, decode_stb
  );

  modport slave (
    output op_pc, uc_nxt, uc_jmp, uc_cond, uc_mem, uc_dly_ld, dly_val,
           mem_ack, flag_z, flag_ac7, cont,
    input  upc, halted, dly_busy, decode_stb
  );

endinterface

// File: rtl/scmp_microcode_seq_dly_counter.sv
// Down-counter for the DLY instruction: load wins over decrement, saturates at 0.
module scmp_dly_counter
  import scmp_microcode_pak::*;
#(
  parameter int W = DLY_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/scmp_microcode_seq.sv
// SC/MP microcode sequencer: owns upc and selects the next microcode address
// each cycle, covering bus stalls, microbranches, HALT wait and DLY countdown.
module scmp_microcode_seq
  import scmp_microcode_pak::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  scmp_microcode_seq_if.master  bus
);

  NEXTPC_t upc_q;
  NEXTPC_t upc_d;
  NEXTPC_t upc_inc;
  logic    stall;
  logic    dly_ld;
  logic    dly_dec;
  logic    dly_zero;

  assign stall   = bus.uc_mem && !bus.mem_ack;
  assign upc_inc = upc_q + NEXTPC_t'(1);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    upc_d   = upc_q;
    dly_ld  = 1'b0;
    dly_dec = 1'b0;
    if (!stall) begin
      dly_ld = bus.uc_dly_ld;
      case (bus.uc_nxt)
        NXT_NEXT:   upc_d = upc_inc;
        NXT_JMP:    upc_d = bus.uc_jmp;
        NXT_COND:   upc_d = cond_met(bus.uc_cond, bus.flag_z, bus.flag_ac7) ? bus.uc_jmp : upc_inc;
        NXT_DECODE: upc_d = bus.op_pc;
        NXT_HALT:   upc_d = bus.cont ? UCLBL_FETCH : upc_q;
        NXT_DLY: begin
          // A load in the DLY step itself holds here; the countdown begins next cycle.
          if (bus.uc_dly_ld) begin
            upc_d = upc_q;
          end else if (!dly_zero) begin
            dly_dec = 1'b1;
          end else begin
            upc_d = upc_inc;
          end
        end
        default:    upc_d = UCLBL_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upc_q <= UCLBL_FETCH;
    end else begin
      upc_q <= upc_d;
    end
  end

  scmp_dly_counter #(.W(DLY_W)) u_dly (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (dly_ld),
    .load_val (bus.dly_val),
    .dec      (dly_dec),
    .zero     (dly_zero)
  );

  assign bus.upc        = upc_q;
  assign bus.halted     = rst_n && (bus.uc_nxt == NXT_HALT);
  assign bus.decode_stb = rst_n && (bus.uc_nxt == NXT_DECODE) && !stall;
  assign bus.dly_busy   = !dly_zero;

endmodule

// File: tb/tb_scmp_microcode_seq.sv
// Bench for scmp_microcode_seq: directed test-plan steps then random microwords,
// all checked against a cycle-level reference model of the sequencing rules.
module tb_scmp_microcode_seq;
  import scmp_microcode_pak::*;

  logic clk;
  logic rst_n;
  scmp_microcode_seq_if bus ();

  scmp_microcode_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int step_no = 0;

  // Reference model state: microcode address and remaining delay count.
  int m_upc;
  int m_cnt;
  localparam int UPC_SPAN = 1 << UPC_W;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s@%0d: observed %0h expected %0h", tag, step_no, obs, exp);
    end
  endtask

  // One microstep: present a microword at negedge, check outputs, advance the model.
  task automatic step(input NXT_t nxt, input int jmp = 0, input COND_t cnd = COND_ALWAYS,
                      input bit mem = 0, input bit ack = 0, input bit ld = 0, input int val = 0,
                      input bit fz = 0, input bit ac7 = 0, input bit cnt_req = 0, input int oppc = 0);
    bit stalled;
    bit take;
    int inc;
    int nxt_upc;
    @(negedge clk);
    step_no++;
    bus.uc_nxt    = nxt;
    bus.uc_jmp    = NEXTPC_t'(jmp);
    bus.uc_cond   = cnd;
    bus.uc_mem    = mem;
    bus.mem_ack   = ack;
    bus.uc_dly_ld = ld;
    bus.dly_val   = DLY_W'(val);
    bus.flag_z    = fz;
    bus.flag_ac7  = ac7;
    bus.cont      = cnt_req;
    bus.op_pc     = NEXTPC_t'(oppc);
    #1;
    stalled = mem && !ack;
    check("upc",        32'(bus.upc),        32'(m_upc));
    check("halted",     32'(bus.halted),     32'(nxt == NXT_HALT));
    check("decode_stb", 32'(bus.decode_stb), 32'((nxt == NXT_DECODE) && !stalled));
    check("dly_busy",   32'(bus.dly_busy),   32'(m_cnt != 0));

    inc     = (m_upc + 1) % UPC_SPAN;
    nxt_upc = m_upc;
    if (!stalled) begin
      if (nxt == NXT_NEXT)        nxt_upc = inc;
      else if (nxt == NXT_JMP)    nxt_upc = jmp % UPC_SPAN;
      else if (nxt == NXT_COND) begin
        take = (cnd == COND_ALWAYS) || (cnd == COND_Z && fz) ||
               (cnd == COND_NZ && !fz) || (cnd == COND_POS && !ac7);
        nxt_upc = take ? jmp % UPC_SPAN : inc;
      end
      else if (nxt == NXT_DECODE) nxt_upc = oppc % UPC_SPAN;
      else if (nxt == NXT_HALT)   nxt_upc = cnt_req ? int'(UCLBL_FETCH) : m_upc;
      else if (nxt == NXT_DLY)    nxt_upc = (ld || m_cnt > 0) ? m_upc : inc;
      else                        nxt_upc = int'(UCLBL_FETCH);

      if (ld)                               m_cnt = val;
      else if (nxt == NXT_DLY && m_cnt > 0) m_cnt = m_cnt - 1;
    end
    m_upc = nxt_upc;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.uc_nxt = NXT_HALT; bus.uc_jmp = '0; bus.uc_cond = COND_ALWAYS;
    bus.uc_mem = 1'b0; bus.uc_dly_ld = 1'b0; bus.dly_val = '0; bus.mem_ack = 1'b0;
    bus.flag_z = 1'b0; bus.flag_ac7 = 1'b0; bus.cont = 1'b0; bus.op_pc = '0;
    m_upc = int'(UCLBL_FETCH);
    m_cnt = 0;

    #12;
    check("rst_upc",    32'(bus.upc),        32'(UCLBL_FETCH));
    check("rst_halted", 32'(bus.halted),     32'd0);
    check("rst_stb",    32'(bus.decode_stb), 32'd0);
    check("rst_busy",   32'(bus.dly_busy),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Decode entry and one-cycle strobe.
    step(NXT_NEXT);
    step(NXT_DECODE, .oppc(8'h23));
    step(NXT_NEXT);

    // Bus stall with a suppressed delay load, then ack.
    repeat (3) step(NXT_NEXT, .mem(1), .ack(0), .ld(1), .val(9));
    step(NXT_NEXT, .mem(1), .ack(1));
    step(NXT_NEXT, .ack(1));

    // Conditional branches, including wrap from 0x7F.
    step(NXT_COND, .jmp(8'h40), .cnd(COND_Z), .fz(1));
    step(NXT_JMP, .jmp(8'h7F));
    step(NXT_COND, .jmp(8'h40), .cnd(COND_Z), .fz(0));
    step(NXT_COND, .jmp(8'h55), .cnd(COND_POS), .ac7(1));
    step(NXT_COND, .jmp(8'h55), .cnd(COND_NZ), .fz(0));
    step(NXT_NEXT);

    // Delay: load 5 then DLY for 6 cycles; load within the DLY step; load 0.
    step(NXT_JMP, .jmp(int'(UCLBL_DLY)), .ld(1), .val(5));
    repeat (6) step(NXT_DLY);
    step(NXT_DLY, .ld(1), .val(2));
    repeat (3) step(NXT_DLY);
    step(NXT_NEXT, .ld(1), .val(0));
    step(NXT_DLY);
    step(NXT_NEXT);

    // HALT without cont, release with cont, and immediate exit on first cycle.
    step(NXT_JMP, .jmp(int'(UCLBL_HALT)), .cnt_req(1));
    repeat (10) step(NXT_HALT);
    step(NXT_HALT, .cnt_req(1));
    step(NXT_JMP, .jmp(int'(UCLBL_HALT)));
    step(NXT_HALT, .cnt_req(1));
    step(NXT_NEXT);

    // Unused next-address code falls back to FETCH.
    step(NXT_t'(3'd7));
    step(NXT_NEXT);

    // Reset in the middle of a long delay.
    step(NXT_JMP, .jmp(int'(UCLBL_DLY)), .ld(1), .val(500));
    repeat (4) step(NXT_DLY);
    #2;
    bus.uc_nxt = NXT_HALT;
    rst_n = 1'b0;
    #1;
    check("mid_rst_upc",    32'(bus.upc),      32'(UCLBL_FETCH));
    check("mid_rst_busy",   32'(bus.dly_busy), 32'd0);
    check("mid_rst_halted", 32'(bus.halted),   32'd0);
    m_upc = int'(UCLBL_FETCH);
    m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(NXT_NEXT);
    step(NXT_NEXT);

    // Random microwords against the model.
    for (int i = 0; i < 400; i++) begin
      NXT_t r_nxt;
      r_nxt = NXT_t'(3'($urandom_range(0, 7)));
      step(r_nxt,
           .jmp(int'($urandom_range(0, UPC_SPAN - 1))),
           .cnd(COND_t'(2'($urandom_range(0, 3)))),
           .mem($urandom_range(0, 3) == 0),
           .ack($urandom_range(0, 1) == 1),
           .ld($urandom_range(0, 5) == 0),
           .val(int'($urandom_range(0, 6))),
           .fz($urandom_range(0, 1) == 1),
           .ac7($urandom_range(0, 1) == 1),
           .cnt_req($urandom_range(0, 3) == 0),
           .oppc(int'($urandom_range(0, UPC_SPAN - 1))));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
